rsa_modexp_sc: RTL
==================

Name: rsa_modexp_sc

Overview:
Parametrised, security-conscious RSA modular-exponentiation core computing cypher = indata^inExp mod inMod. Successor to the fixed-width RSACypher_sc: exponent width is separate from modulus width, and the core is strictly constant-time. It uses square-and-always-multiply over a bit-serial Blakley modular multiplier. Per-input security labels are captured with the operands and propagated to the result. The core is instantiated in pairs inside miters for non-interference proofs.

Parameters:
KEYSIZE, 32, width of indata, inMod and cypher.
EXP_BITS, KEYSIZE, width of inExp (number of exponent bits scanned).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
indata  input  KEYSIZE  message or base.
inExp  input  EXP_BITS  exponent.
inMod  input  KEYSIZE  modulus.
ds  input  1  data strobe; starts an operation when sampled high while ready=1.
indata_label  input  1  security label of indata (1 = secret).
inExp_label  input  1  security label of inExp.
inMod_label  input  1  security label of inMod.
cypher  output  KEYSIZE  result; held until the next accepted ds.
ready  output  1  1 = idle or result valid; 0 = busy.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, cypher=0, ready=1, all operand registers and captured labels cleared.
- States: IDLE -> REDUCE -> SQR -> MUL -> (SQR or FINISH) -> IDLE.
- IDLE: on ds=1, latch indata, inExp, inMod and the three labels. Set ready=0 on the next cycle. Go to REDUCE.
- REDUCE: base = indata*1 mod inMod, so indata >= inMod is handled. Set acc=1.
- For i = EXP_BITS-1 down to 0:
  - SQR: acc = acc*acc mod M.
  - MUL: t = acc*base mod M, always computed.
  - acc = inExp[i] ? t : acc, via a mux only. No control flow depends on operand values.
- FINISH: cypher = (inMod < 2) ? 0 : acc. Set ready=1. Go to IDLE.
- Modular multiply (Blakley), per multiply:
  - 1 load cycle, then KEYSIZE iteration cycles, MSB of multiplier first.
  - Each iteration: R = 2R + (a_i ? B : 0), then at most two conditional subtractions of M.
  - Internal R width is KEYSIZE+2, with no overflow.
  - Each multiply takes exactly KEYSIZE+1 cycles.
- Latency: ds sampled high at edge 0; ready rises at edge L = (2*EXP_BITS+1)*(KEYSIZE+1)+2. L is independent of all data and label values.
- Edge cases:
  - inExp=0 gives cypher = 1 mod inMod.
  - inMod=0 or inMod=1 gives cypher=0 with the same latency.
- ds while busy is ignored: operands are not relatched and the running computation is unaffected.
- Reset mid-operation returns to the reset values immediately. No partial result appears on cypher.
- cypher changes only in the FINISH cycle. It is stable while ready=1.
- Label rule:
  - Captured label L_res = indata_label | inExp_label | inMod_label, updated at accepted ds.
  - No control signal (ready, state, latency) may depend on data or labels. ready and the state are therefore always public.

Optional Feature:
Macro RSA_SC_LABEL_OUT_EN.
- Defined: adds output port cypher_label (1 bit). Reset value 0. It is updated to L_res in the FINISH cycle, together with cypher, and holds until the next FINISH or reset.
- Not defined: the port is absent and labels are captured but unobservable. Function and timing are identical in both builds.

Decomposition:
- Package rsa_sc_pkg contains:
  - the state enum (IDLE, REDUCE, SQR, MUL, FINISH);
  - a function for the latency constant L(KEYSIZE, EXP_BITS);
  - a label type label_t (1-bit logic).
- One sub-module, rsa_modmul_blakley, parametrised by KEYSIZE.
  - Inputs: start, a, b, m.
  - Outputs: busy, done, p.
  - It runs a fixed KEYSIZE+1 cycles with the same clk/rst.

Test Plan (KEYSIZE=8, EXP_BITS=8, L=155):
- indata=4, inExp=13, inMod=77, ds pulse -> ready=0 from edge 1; ready=1 and cypher=53 at edge 155.
- indata=200, inExp=3, inMod=13 (base >= modulus) -> cypher=8 at edge 155.
- inExp=0, inMod=77 -> cypher=1; then inMod=1 -> cypher=0. Both runs take exactly 155 cycles.
- Reset cases:
  - rst pulsed low at edge 60 of a run -> cypher=0 and ready=1 immediately.
  - ds re-pulsed at edge 30 of a run -> ignored; original result 53 still at edge 155.
- Two runs with inExp=0x01 and inExp=0xFF (inExp_label=1) -> identical ready waveforms, ready rising at edge 155 in both. With RSA_SC_LABEL_OUT_EN defined: cypher_label=1 at edge 155, and 0 when all labels are 0.

Source files
------------

// File: rtl/rsa_sc_pkg.sv
// Shared types and helpers for the constant-time RSA modular-exponentiation core.
// Holds the top-level state encoding, the security-label types and the
// data-independent latency constant of one exponentiation.
package rsa_sc_pkg;

    // Top-level sequencing states; each multiply state spans one full Blakley run.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SQR    = 3'd2,
        MUL    = 3'd3,
        FINISH = 3'd4
    } state_e;

    // One-bit security label: 1 = secret, 0 = public.
    typedef logic label_t;

    // Labels captured together with the operands at an accepted strobe.
    typedef struct packed {
        label_t indata;
        label_t exponent;
        label_t modulus;
    } labels_t;

    // Edges from the accepting strobe edge to the edge where ready rises:
    // (one reduction + two multiplies per exponent bit) * (load + KEYSIZE
    // iterations) + the final hand-off cycle + the FINISH cycle.
    function automatic int unsigned modexp_latency(input int unsigned keysize,
                                                   input int unsigned exp_bits);
        return (2 * exp_bits + 1) * (keysize + 1) + 2;
    endfunction

endpackage

// File: rtl/rsa_modexp_sc_if.sv
// Operand/result bundle of rsa_modexp_sc.
// The master side supplies operands, labels and the strobe; the slave side
// (the core) returns the result and ready. When RSA_SC_LABEL_OUT_EN is defined
// the bundle also carries the result label cypher_label.
interface rsa_modexp_sc_if #(
    parameter int KEYSIZE  = 32,
    parameter int EXP_BITS = KEYSIZE
);

    logic [KEYSIZE-1:0]    indata;
    logic [EXP_BITS-1:0]   inExp;
    logic [KEYSIZE-1:0]    inMod;
    logic                  ds;
    rsa_sc_pkg::label_t    indata_label;
    rsa_sc_pkg::label_t    inExp_label;
    rsa_sc_pkg::label_t    inMod_label;
    logic [KEYSIZE-1:0]    cypher;
    logic                  ready;
`ifdef RSA_SC_LABEL_OUT_EN
    rsa_sc_pkg::label_t    cypher_label;

    modport master (
        output indata, inExp, inMod, ds, indata_label, inExp_label, inMod_label,
        input  cypher, ready, cypher_label
    );

    modport slave (
        input  indata, inExp, inMod, ds, indata_label, inExp_label, inMod_label,
        output cypher, ready, cypher_label
    );
`else
    modport master (
        output indata, inExp, inMod, ds, indata_label, inExp_label, inMod_label,
        input  cypher, ready
    );

    modport slave (
        input  indata, inExp, inMod, ds, indata_label, inExp_label, inMod_label,
        output cypher, ready
    );
`endif

endinterface

// File: rtl/rsa_modmul_blakley.sv
// Bit-serial Blakley modular multiplier: p = a * b mod m.
// One load cycle (start sampled) followed by exactly KEYSIZE iteration cycles,
// multiplier a scanned MSB first. Each iteration computes R = 2R + (a_i ? b : 0)
// and applies two conditional subtractions of m. With R < m and b < m on entry,
// 2R + b < 3m fits in KEYSIZE+2 bits. done pulses for one cycle after the last
// iteration, when p is valid; p holds until the next start.
module rsa_modmul_blakley #(
    parameter int KEYSIZE = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEYSIZE-1:0] a,
    input  logic [KEYSIZE-1:0] b,
    input  logic [KEYSIZE-1:0] m,
    output logic               busy,
    output logic               done,
    output logic [KEYSIZE-1:0] p
);

    localparam int RW    = KEYSIZE + 2;
    localparam int CNT_W = (KEYSIZE > 1) ? $clog2(KEYSIZE) : 1;

    logic [RW-1:0]      r_q, r_d;
    logic [KEYSIZE-1:0] a_q, a_d;
    logic [KEYSIZE-1:0] b_q, b_d;
    logic [KEYSIZE-1:0] m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [RW-1:0]      m_ext;
    logic [RW-1:0]      r_add;
    logic [RW-1:0]      r_sub1;
    logic [RW-1:0]      r_sub2;

    // Load on start, otherwise run one Blakley step per cycle while busy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        r_d    = r_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        m_ext  = {2'b00, m_q};
        r_add  = (r_q << 1) + (a_q[KEYSIZE-1] ? {2'b00, b_q} : '0);
        r_sub1 = (r_add  >= m_ext) ? (r_add  - m_ext) : r_add;
        r_sub2 = (r_sub1 >= m_ext) ? (r_sub1 - m_ext) : r_sub1;

        if (start) begin
            r_d    = '0;
            a_d    = a;
            b_d    = b;
            m_d    = m;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            r_d   = r_sub2;
            a_d   = a_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEYSIZE - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and control registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state is updated with <= only, so every flop samples pre-edge values.
        if (!rst) begin
            r_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = r_q[KEYSIZE-1:0];

endmodule

// File: rtl/rsa_modexp_sc.sv
// Constant-time RSA modular exponentiation: cypher = indata ^ inExp mod inMod.
// Square-and-always-multiply over a Blakley multiplier; the exponent bit only
// steers a result mux, so sequencing and latency never depend on operands or
// labels. Labels are captured with the operands at an accepted strobe.
// Optional build macro RSA_SC_LABEL_OUT_EN exposes the OR of the captured
// labels as cypher_label, updated together with cypher.
module rsa_modexp_sc
    import rsa_sc_pkg::*;
#(
    parameter int KEYSIZE  = 32,
    parameter int EXP_BITS = KEYSIZE
) (
    input  logic            clk,
    input  logic            rst,
    rsa_modexp_sc_if.slave  bus
);

    localparam int IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

    state_e                state_q, state_d;
    logic [KEYSIZE-1:0]    indata_q, indata_d;
    logic [EXP_BITS-1:0]   inexp_q, inexp_d;
    logic [KEYSIZE-1:0]    inmod_q, inmod_d;
    labels_t               labels_q, labels_d;
    logic [KEYSIZE-1:0]    base_q, base_d;
    logic [KEYSIZE-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [KEYSIZE-1:0]    cypher_q, cypher_d;
    logic                  ready_q, ready_d;
`ifdef RSA_SC_LABEL_OUT_EN
    label_t                cypher_label_q, cypher_label_d;
`endif

    logic                  mul_start;
    logic [KEYSIZE-1:0]    mul_a;
    logic [KEYSIZE-1:0]    mul_b;
    logic                  mul_busy;
    logic                  mul_done;
    logic [KEYSIZE-1:0]    mul_p;

    rsa_modmul_blakley #(
        .KEYSIZE (KEYSIZE)
    ) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (inmod_q),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Sequencer: each multiply result is consumed in its done cycle and the
    // next multiply is launched in that same cycle, so runs are back to back.
    always_comb begin
        state_d   = state_q;
        indata_d  = indata_q;
        inexp_d   = inexp_q;
        inmod_d   = inmod_q;
        labels_d  = labels_q;
        base_d    = base_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        cypher_d  = cypher_q;
        ready_d   = ready_q;
`ifdef RSA_SC_LABEL_OUT_EN
        cypher_label_d = cypher_label_q;
`endif
        mul_start = 1'b0;
        mul_a     = acc_q;
        mul_b     = acc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.ds) begin
                    indata_d = bus.indata;
                    inexp_d  = bus.inExp;
                    inmod_d  = bus.inMod;
                    labels_d = '{indata:   bus.indata_label,
                                 exponent: bus.inExp_label,
                                 modulus:  bus.inMod_label};
                    state_d  = REDUCE;
                end
            end

            REDUCE: begin
                // base = indata * 1 mod M folds indata >= M into range.
                ready_d = 1'b0;
                mul_a   = indata_q;
                mul_b   = KEYSIZE'(1);
                if (mul_done) begin
                    base_d    = mul_p;
                    acc_d     = KEYSIZE'(1);
                    bit_idx_d = IDX_W'(EXP_BITS - 1);
                    mul_start = 1'b1;
                    mul_a     = KEYSIZE'(1);
                    mul_b     = KEYSIZE'(1);
                    state_d   = SQR;
                end else if (!mul_busy) begin
                    mul_start = 1'b1;
                end
            end

            SQR: begin
                if (mul_done) begin
                    acc_d     = mul_p;
                    mul_start = 1'b1;
                    mul_a     = mul_p;
                    mul_b     = base_q;
                    state_d   = MUL;
                end
            end

            MUL: begin
                if (mul_done) begin
                    // The product is always computed; the exponent bit only selects it.
                    acc_d = inexp_q[bit_idx_q] ? mul_p : acc_q;
                    if (bit_idx_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        mul_start = 1'b1;
                        mul_a     = acc_d;
                        mul_b     = acc_d;
                        state_d   = SQR;
                    end
                end
            end

            FINISH: begin
                // Moduli 0 and 1 have no meaningful residue other than 0.
                cypher_d = (inmod_q < KEYSIZE'(2)) ? '0 : acc_q;
                ready_d  = 1'b1;
`ifdef RSA_SC_LABEL_OUT_EN
                cypher_label_d = labels_q.indata | labels_q.exponent | labels_q.modulus;
`endif
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Architectural state; reset returns to idle with a public zero result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            indata_q  <= '0;
            inexp_q   <= '0;
            inmod_q   <= '0;
            labels_q  <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
            cypher_q  <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            indata_q  <= indata_d;
            inexp_q   <= inexp_d;
            inmod_q   <= inmod_d;
            labels_q  <= labels_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            cypher_q  <= cypher_d;
            ready_q   <= ready_d;
        end
    end

`ifdef RSA_SC_LABEL_OUT_EN
    // Result label register, written only alongside cypher.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cypher_label_q <= 1'b0;
        end else begin
            cypher_label_q <= cypher_label_d;
        end
    end

    assign bus.cypher_label = cypher_label_q;
`else
    // Labels are still captured in this build but have no observer.
    logic unused_labels;
    assign unused_labels = ^labels_q;
`endif

    assign bus.cypher = cypher_q;
    assign bus.ready  = ready_q;

endmodule
